// File: rtl/aemb_dwb_sram_slave.sv
// Wishbone classic-cycle SRAM slave for the core's data bus.
// Big-endian byte lanes, programmable wait states, registered ack/err/data.
module aemb_dwb_sram_slave #(
    parameter int AW    = 10,
    parameter int WAITS = 1
) (
    input  logic        nclk,
    input  logic        frst,
    input  logic [31:0] dwb_adr_i,
    input  logic [31:0] dwb_dat_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic        dwb_stb_i,
    input  logic        dwb_we_i,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_ack_o,
    output logic        dwb_err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_RESP  = 2'd2,
        S_RECOV = 2'd3
    } state_t;

    localparam logic [3:0] LP_WAIT_LOAD = (WAITS > 0) ? 4'(WAITS - 1) : 4'd0;

    logic [31:0]   r_mem [2**AW];
    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic          w_enter_resp;
    logic          w_in_range;
    logic [AW-1:0] w_word;
    logic          w_unused;

    assign w_in_range = (dwb_adr_i[31:AW+2] == '0);
    assign w_word     = dwb_adr_i[AW+1:2];
    assign w_unused   = ^dwb_adr_i[1:0];

    // State and wait-counter registers
    always_ff @(posedge nclk or negedge frst) begin
        if (!frst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; w_enter_resp marks the single edge that commits the transfer
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dwb_stb_i) begin
                    if (WAITS > 0) begin
                        w_cnt_nxt   = LP_WAIT_LOAD;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!dwb_stb_i) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP:  w_state_nxt = S_RECOV;
            S_RECOV: w_state_nxt = S_IDLE;
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Registered response: ack/err/data live for exactly the RESP cycle
    always_ff @(posedge nclk or negedge frst) begin
        if (!frst) begin
            dwb_ack_o <= 1'b0;
            dwb_err_o <= 1'b0;
            dwb_dat_o <= 32'd0;
        end else if (w_enter_resp) begin
            if (!w_in_range) begin
                dwb_ack_o <= 1'b0;
                dwb_err_o <= 1'b1;
                dwb_dat_o <= 32'd0;
            end else if (dwb_we_i) begin
                dwb_ack_o <= 1'b1;
                dwb_err_o <= 1'b0;
                dwb_dat_o <= 32'd0;
            end else begin
                dwb_ack_o <= 1'b1;
                dwb_err_o <= 1'b0;
                dwb_dat_o <= r_mem[w_word];
            end
        end else begin
            dwb_ack_o <= 1'b0;
            dwb_err_o <= 1'b0;
            dwb_dat_o <= 32'd0;
        end
    end

    // Storage array, not reset; sel[3] is byte offset 0 (bits 31:24)
    always_ff @(posedge nclk) begin
        if (frst && w_enter_resp && w_in_range && dwb_we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (dwb_sel_i[i]) begin
                    r_mem[w_word][8*i +: 8] <= dwb_dat_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_aemb_dwb_sram_slave.sv
// Bench for aemb_dwb_sram_slave: three instances (WAITS = 0, 2, 3) against a
// word-array reference model, directed cases plus randomized transfers.
module tb_aemb_dwb_sram_slave;

    logic        nclk;
    logic        frst;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we;
    logic        stb   [3];
    logic [31:0] dat_o [3];
    logic        ack   [3];
    logic        err   [3];

    int checks = 0;
    int errors = 0;
    int wt [3] = '{0, 2, 3};
    bit [31:0] mdl [3][1024];

    aemb_dwb_sram_slave #(.AW(10), .WAITS(0)) u_w0 (
        .nclk(nclk), .frst(frst), .dwb_adr_i(adr), .dwb_dat_i(dat_i), .dwb_sel_i(sel),
        .dwb_stb_i(stb[0]), .dwb_we_i(we), .dwb_dat_o(dat_o[0]), .dwb_ack_o(ack[0]), .dwb_err_o(err[0]));
    aemb_dwb_sram_slave #(.AW(10), .WAITS(2)) u_w2 (
        .nclk(nclk), .frst(frst), .dwb_adr_i(adr), .dwb_dat_i(dat_i), .dwb_sel_i(sel),
        .dwb_stb_i(stb[1]), .dwb_we_i(we), .dwb_dat_o(dat_o[1]), .dwb_ack_o(ack[1]), .dwb_err_o(err[1]));
    aemb_dwb_sram_slave #(.AW(10), .WAITS(3)) u_w3 (
        .nclk(nclk), .frst(frst), .dwb_adr_i(adr), .dwb_dat_i(dat_i), .dwb_sel_i(sel),
        .dwb_stb_i(stb[2]), .dwb_we_i(we), .dwb_dat_o(dat_o[2]), .dwb_ack_o(ack[2]), .dwb_err_o(err[2]));

    initial nclk = 1'b0;
    always #5 nclk = ~nclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete strobe on instance k, checked against the reference model
    task automatic xfer(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input string tag);
        int cyc = 0;
        bit seen = 1'b0;
        bit inr;
        logic [31:0] exp_d;
        adr = a; dat_i = d; sel = s; we = w; stb[k] = 1'b1;
        while (!seen && cyc < 40) begin
            @(negedge nclk);
            cyc++;
            if (ack[k] || err[k]) seen = 1'b1;
        end
        inr   = (a[31:12] == 20'd0);
        exp_d = (inr && !w) ? mdl[k][a[11:2]] : 32'd0;
        chk({tag, " latency"}, 32'(cyc), 32'(wt[k] + 1));
        chk({tag, " ack"}, {31'd0, ack[k]}, {31'd0, inr});
        chk({tag, " err"}, {31'd0, err[k]}, {31'd0, !inr});
        chk({tag, " dat"}, dat_o[k], exp_d);
        if (inr && w) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) mdl[k][a[11:2]][8*i +: 8] = d[8*i +: 8];
        end
        stb[k] = 1'b0;
        @(negedge nclk);
        chk({tag, " pulse"}, {30'd0, ack[k], err[k]}, 32'd0);
        @(negedge nclk);
    endtask

    initial begin
        frst = 1'b0; adr = 32'd0; dat_i = 32'd0; sel = 4'd0; we = 1'b0;
        for (int k = 0; k < 3; k++) stb[k] = 1'b0;
        repeat (2) @(negedge nclk);
        for (int k = 0; k < 3; k++) begin
            chk("reset ack", {31'd0, ack[k]}, 32'd0);
            chk("reset err", {31'd0, err[k]}, 32'd0);
            chk("reset dat", dat_o[k], 32'd0);
        end
        frst = 1'b1;
        @(negedge nclk);

        // Preload a small working set (words 0..14 and the top word) in every instance
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 16; j++)
                xfer(k, 1'b1, (j == 15) ? 32'hFFC : 32'(j * 4), (j == 4) ? 32'd0 : $urandom, 4'hF, "preload");
        end

        // Held strobe: acks exactly once per WAITS+3 cycles, first at WAITS+1
        for (int k = 0; k < 2; k++) begin
            adr = 32'd0; we = 1'b0; sel = 4'hF; stb[k] = 1'b1;
            for (int c = 1; c <= 15; c++) begin
                @(negedge nclk);
                chk("hold ack", {31'd0, ack[k]},
                    {31'd0, ((c % (wt[k] + 3)) == (wt[k] + 1))});
            end
            stb[k] = 1'b0;
            repeat (4) @(negedge nclk);
        end

        // Byte lanes, big-endian
        xfer(1, 1'b1, 32'h20, 32'h11223344, 4'hF, "lane w1");
        xfer(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b1001, "lane w2");
        xfer(1, 1'b0, 32'h20, 32'd0, 4'hF, "lane rd");
        chk("lane const", mdl[1][8], 32'hAA2233DD);

        // Write with sel = 0 still acks and leaves memory alone
        xfer(1, 1'b1, 32'h24, 32'h55555555, 4'h0, "sel0 w");
        xfer(1, 1'b0, 32'h24, 32'd0, 4'hF, "sel0 rd");

        // Sel ignored on read
        xfer(0, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, "selrd w");
        xfer(0, 1'b0, 32'h8, 32'd0, 4'b0001, "selrd rd");

        // Range: first out-of-range word, top in-range word, aliasing word 0 untouched
        xfer(0, 1'b1, 32'h00001000, 32'h12345678, 4'hF, "range w");
        xfer(0, 1'b0, 32'h00000FFC, 32'd0, 4'hF, "range top");
        xfer(0, 1'b0, 32'h00000000, 32'd0, 4'hF, "range alias");

        // Abort during WAIT on WAITS=2
        adr = 32'h40; dat_i = 32'hDEADBEEF; sel = 4'hF; we = 1'b1; stb[1] = 1'b1;
        @(negedge nclk);
        stb[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge nclk);
            chk("abort resp", {30'd0, ack[1], err[1]}, 32'd0);
        end
        xfer(1, 1'b0, 32'h40, 32'd0, 4'hF, "abort rd");

        // Reset asserted in the 2nd WAIT cycle on WAITS=3
        xfer(2, 1'b1, 32'h10, 32'h00000000, 4'hF, "rst pre");
        adr = 32'h10; dat_i = 32'hFFFFFFFF; sel = 4'hF; we = 1'b1; stb[2] = 1'b1;
        repeat (2) @(negedge nclk);
        frst = 1'b0;
        #1;
        chk("rst async", {30'd0, ack[2], err[2]}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge nclk);
            chk("rst hold", {30'd0, ack[2], err[2]}, 32'd0);
        end
        stb[2] = 1'b0;
        @(negedge nclk);
        frst = 1'b1;
        @(negedge nclk);
        xfer(2, 1'b0, 32'h10, 32'd0, 4'hF, "rst rd");
        chk("rst const", mdl[2][4], 32'h00000000);

        // Randomized traffic over the preloaded working set, with some out-of-range hits
        for (int n = 0; n < 120; n++) begin
            int k;
            int j;
            logic [31:0] a;
            k = $urandom_range(2, 0);
            j = $urandom_range(15, 0);
            a = {20'd0, (j == 15) ? 10'd1023 : 10'(j), 2'($urandom_range(3, 0))};
            if ($urandom_range(7, 0) == 0) a[31:12] = 20'($urandom_range(20'hFFFFF, 1));
            xfer(k, 1'($urandom_range(1, 0)), a, $urandom, 4'($urandom_range(15, 0)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
